// File: rtl/vector_bit_iterator.sv
// Enumerates the set bits of an accepted vector, LSB first, one beat per handshake.
// Each beat carries the isolated bit (one-hot), its binary index and its ordinal.
module vector_bit_iterator #(
    parameter int unsigned VECTOR_WIDTH = 16,
    parameter int unsigned IDX_WIDTH    = $clog2(VECTOR_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [VECTOR_WIDTH-1:0] i_in_vec,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [VECTOR_WIDTH-1:0] o_out_onehot,
    output logic [IDX_WIDTH-1:0]    o_out_idx,
    output logic [IDX_WIDTH-1:0]    o_out_seq,
    output logic                    o_out_last,
    output logic                    o_empty_pulse
);

    typedef enum logic [0:0] {StIdle, StIter} state_e;

    state_e                  r_state;
    logic [VECTOR_WIDTH-1:0] r_residue;
    logic [IDX_WIDTH-1:0]    r_seq;
    logic                    r_empty_pulse;

    logic [VECTOR_WIDTH-1:0] w_onehot;
    logic [IDX_WIDTH-1:0]    w_idx;
    logic                    w_last;

    // Isolate the lowest set bit of the residue; carry out of the negation is dropped.
    assign w_onehot = r_residue & (~r_residue + VECTOR_WIDTH'(1));
    // Last beat when nothing remains above the isolated bit.
    assign w_last   = (r_residue & ~w_onehot) == '0;

    // One-hot to binary encoder; OR-reduction keeps it free of priority logic.
    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < VECTOR_WIDTH; i++) begin
            if (w_onehot[i]) begin
                w_idx = w_idx | IDX_WIDTH'(i);
            end
        end
    end

    // Control FSM: accept a vector in idle, strip one bit per handshake in iter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_residue     <= '0;
            r_seq         <= '0;
            r_empty_pulse <= 1'b0;
        end else begin
            r_empty_pulse <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        if (i_in_vec != '0) begin
                            r_residue <= i_in_vec;
                            r_seq     <= '0;
                            r_state   <= StIter;
                        end else begin
                            // Nothing to enumerate: signal it and stay idle.
                            r_empty_pulse <= 1'b1;
                        end
                    end
                end
                StIter: begin
                    if (i_out_ready) begin
                        if (w_last) begin
                            r_state   <= StIdle;
                            r_residue <= '0;
                            r_seq     <= '0;
                        end else begin
                            r_residue <= r_residue & ~w_onehot;
                            r_seq     <= r_seq + IDX_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // All outputs decode from registers only, so they hold while the sink stalls.
    assign o_in_ready    = (r_state == StIdle);
    assign o_out_valid   = (r_state == StIter);
    assign o_out_onehot  = w_onehot;
    assign o_out_idx     = w_idx;
    assign o_out_seq     = r_seq;
    assign o_out_last    = (r_state == StIter) && w_last;
    assign o_empty_pulse = r_empty_pulse;

endmodule

// File: tb/tb_vector_bit_iterator.sv
// Directed self-checking bench for vector_bit_iterator (16-bit configuration).
module tb_vector_bit_iterator;

    localparam int W  = 16;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_onehot;
    logic [IW-1:0] out_idx;
    logic [IW-1:0] out_seq;
    logic          out_last;
    logic          empty_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    vector_bit_iterator #(
        .VECTOR_WIDTH(W),
        .IDX_WIDTH   (IW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_vec     (in_vec),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_onehot (out_onehot),
        .o_out_idx    (out_idx),
        .o_out_seq    (out_seq),
        .o_out_last   (out_last),
        .o_empty_pulse(empty_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            load;
        logic [W-1:0]  vec;
        logic [W-1:0]  onehot;
        logic [IW-1:0] idx;
        logic [IW-1:0] seq;
        bit            last;
    } beat_t;

    beat_t tbl[$];

    function automatic void add(input bit load, input logic [W-1:0] vec,
                                input logic [W-1:0] oh, input int idx, input int seq,
                                input bit last);
        beat_t b;
        b.load   = load;
        b.vec    = vec;
        b.onehot = oh;
        b.idx    = IW'(idx);
        b.seq    = IW'(seq);
        b.last   = last;
        tbl.push_back(b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic [W-1:0] oh, input int idx,
                            input int seq, input bit last);
        chk({name, ".valid"},  32'(out_valid),  32'd1);
        chk({name, ".ready"},  32'(in_ready),   32'd0);
        chk({name, ".onehot"}, 32'(out_onehot), 32'(oh));
        chk({name, ".idx"},    32'(out_idx),    32'(idx));
        chk({name, ".seq"},    32'(out_seq),    32'(seq));
        chk({name, ".last"},   32'(out_last),   32'(last));
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".valid"}, 32'(out_valid), 32'd0);
        chk({name, ".ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        // Table: 0x0012, 0xFFFF, MSB only, 0x0101; all with out_ready held high.
        add(1'b1, 16'h0012, 16'h0002, 1, 0, 1'b0);
        add(1'b0, 16'h0000, 16'h0010, 4, 1, 1'b1);
        for (int i = 0; i < W; i++) begin
            add(i == 0, 16'hFFFF, 16'(1) << i, i, i, i == W - 1);
        end
        add(1'b1, 16'h8000, 16'h8000, 15, 0, 1'b1);
        add(1'b1, 16'h0101, 16'h0001, 0, 0, 1'b0);
        add(1'b0, 16'h0000, 16'h0100, 8, 1, 1'b1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        #2;
        chk_idle("reset");
        chk("reset.seq",   32'(out_seq),     32'd0);
        chk("reset.empty", 32'(empty_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven stream, one beat per cycle.
        foreach (tbl[k]) begin
            if (tbl[k].load) begin
                chk_idle($sformatf("tbl%0d.pre", k));
                in_valid = 1'b1;
                in_vec   = tbl[k].vec;
                @(negedge clk);
                in_valid = 1'b0;
            end
            chk_beat($sformatf("tbl%0d", k), tbl[k].onehot, int'(tbl[k].idx),
                     int'(tbl[k].seq), tbl[k].last);
            @(negedge clk);
            if (tbl[k].last) chk_idle($sformatf("tbl%0d.post", k));
        end

        // All-zero vector: single empty pulse, no beat.
        in_valid = 1'b1;
        in_vec   = 16'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("zero.empty", 32'(empty_pulse), 32'd1);
        chk_idle("zero");
        @(negedge clk);
        chk("zero.empty2", 32'(empty_pulse), 32'd0);
        chk_idle("zero2");

        // Backpressure: first beat must hold while out_ready is low.
        in_valid  = 1'b1;
        in_vec    = 16'h8001;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_beat($sformatf("stall%0d", c), 16'h0001, 0, 0, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk_beat("stall.b0", 16'h0001, 0, 0, 1'b0);
        @(negedge clk);
        chk_beat("stall.b1", 16'h8000, 15, 1, 1'b1);
        @(negedge clk);
        chk_idle("stall.post");

        // Reset mid-iteration drops the vector immediately.
        in_valid = 1'b1;
        in_vec   = 16'hA5A5;
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat("a5.b0", 16'h0001, 0, 0, 1'b0);
        @(negedge clk);
        chk_beat("a5.b1", 16'h0004, 2, 1, 1'b0);
        @(negedge clk);
        chk_beat("a5.b2", 16'h0020, 5, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_idle("a5.rst");
        chk("a5.rst.seq", 32'(out_seq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("a5.after");
        in_valid = 1'b1;
        in_vec   = 16'h0100;
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat("r100", 16'h0100, 8, 0, 1'b1);
        @(negedge clk);
        chk_idle("r100.post");

        // in_vec changes during iteration with in_valid held: ignored until idle.
        in_valid = 1'b1;
        in_vec   = 16'h0003;
        @(negedge clk);
        in_vec = 16'h0F00;
        chk_beat("chg.b0", 16'h0001, 0, 0, 1'b0);
        @(negedge clk);
        chk_beat("chg.b1", 16'h0002, 1, 1, 1'b1);
        @(negedge clk);
        chk_idle("chg.gap");
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk_beat($sformatf("chg.f%0d", j), 16'(1) << (8 + j), 8 + j, j, j == 3);
            @(negedge clk);
        end
        chk_idle("chg.post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
